// File: rtl/ceres_param_pkg.sv
// Shared Ceres parameters used by the performance-monitor block:
// HPM CSR address map, OF bit position and the event-register layout.
package ceres_param;

  localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT_BASE = 12'h320;
  localparam logic [11:0] CSR_MHPMCNT_BASE   = 12'hB00;
  localparam logic [11:0] CSR_MHPMCNTH_BASE  = 12'hB80;
  localparam logic [11:0] CSR_HPMCNT_BASE    = 12'hC00;
  localparam logic [11:0] CSR_HPMCNTH_BASE   = 12'hC80;

  // First HPM index; indices 0..2 belong to cycle/time/instret.
  localparam int unsigned HPM_FIRST  = 3;
  localparam int unsigned HPM_OF_BIT = 31;

  // Architecturally visible part of mhpmeventN.
  typedef struct packed {
    logic       of;
    logic [7:0] sel;
  } hpm_event_t;

endpackage

// File: rtl/ceres_hpm_unit_counter.sv
// One HPM counter slot: counter register, event register, increment,
// wrap/overflow logic and the low/high software write ports.
module hpm_counter
  import ceres_param::*;
#(
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  count_en_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  inhibit_i,
  input  logic                  evt_wr_i,
  input  logic                  lo_wr_i,
  input  logic                  hi_wr_i,
  input  logic [31:0]           wdata_i,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output hpm_event_t            evt_o
);

  localparam logic [CNT_WIDTH-1:0] ONE = 1;

  logic [CNT_WIDTH-1:0] r_cnt;
  hpm_event_t           r_evt;
  logic                 w_sel_hit;
  logic                 w_inc;
  logic                 w_wrap;

  // Select the event line; SEL=0 or SEL beyond the bus matches nothing.
  always_comb begin
    w_sel_hit = 1'b0;
    for (int e = 0; e < NUM_EVENTS; e++) begin
      if (r_evt.sel == 8'(e + 1)) w_sel_hit = event_i[e];
    end
  end

  // A software write to either half suppresses this cycle's increment.
  assign w_inc  = count_en_i & w_sel_hit & ~inhibit_i & ~(lo_wr_i | hi_wr_i);
  assign w_wrap = w_inc & (&r_cnt);

  // Counter register: software writes win over counting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      r_cnt <= '0;
    else if (lo_wr_i) r_cnt[31:0] <= wdata_i;
    else if (hi_wr_i) r_cnt[CNT_WIDTH-1:32] <= wdata_i[CNT_WIDTH-33:0];
    else if (w_inc)   r_cnt <= r_cnt + ONE;
  end

  // Event register; OF is sticky and only software can clear it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_evt <= '0;
    end else if (evt_wr_i) begin
      r_evt.of  <= wdata_i[HPM_OF_BIT];
      r_evt.sel <= wdata_i[7:0];
    end else if (w_wrap) begin
      r_evt.of  <= 1'b1;
    end
  end

  assign cnt_o = r_cnt;
  assign evt_o = r_evt;

endmodule

// File: rtl/ceres_hpm_unit.sv
// Ceres hardware performance monitor: mcountinhibit, NUM_CNT event
// counters with user shadows, CSR decode/read mux and overflow interrupt.
module ceres_hpm_unit
  import ceres_param::*;
#(
  parameter int NUM_CNT    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  count_en_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  csr_rd_en_i,
  input  logic                  csr_wr_en_i,
  input  logic [11:0]           csr_idx_i,
  input  logic [31:0]           csr_wdata_i,
  output logic [31:0]           csr_rdata_o,
  output logic                  csr_hit_o,
  output logic                  cy_inhibit_o,
  output logic                  ir_inhibit_o,
  output logic                  ovf_irq_o
);

  // Writable inhibit bits: CY, IR and one per implemented counter.
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_CNT) - 32'h1) << HPM_FIRST);

  logic [31:0]                          r_minh;
  logic [4:0]                           w_num;
  logic [6:0]                           w_grp;
  logic                                 w_num_ok;
  logic                                 w_is_inh, w_is_evt, w_is_lo, w_is_hi, w_is_slo, w_is_shi;
  logic [NUM_CNT-1:0]                   w_sel;
  logic [NUM_CNT-1:0][CNT_WIDTH-1:0]    w_cnt;
  logic [NUM_CNT-1:0][63:0]             w_ext;
  hpm_event_t [NUM_CNT-1:0]             w_evt;
  logic [31:0]                          w_rdata;
  logic                                 w_irq;

  // Address decode: each HPM group is a 32-entry block, entries 0..2 unowned.
  assign w_num    = csr_idx_i[4:0];
  assign w_grp    = csr_idx_i[11:5];
  assign w_num_ok = (w_num >= 5'(HPM_FIRST));
  assign w_is_inh = (csr_idx_i == CSR_MCOUNTINHIBIT);
  assign w_is_evt = w_num_ok && (w_grp == CSR_MHPMEVENT_BASE[11:5]);
  assign w_is_lo  = w_num_ok && (w_grp == CSR_MHPMCNT_BASE[11:5]);
  assign w_is_hi  = w_num_ok && (w_grp == CSR_MHPMCNTH_BASE[11:5]);
  assign w_is_slo = w_num_ok && (w_grp == CSR_HPMCNT_BASE[11:5]);
  assign w_is_shi = w_num_ok && (w_grp == CSR_HPMCNTH_BASE[11:5]);
  assign csr_hit_o = w_is_inh | w_is_evt | w_is_lo | w_is_hi | w_is_slo | w_is_shi;

  // mcountinhibit; unimplemented bits are never stored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        r_minh <= '0;
    else if (csr_wr_en_i && w_is_inh)   r_minh <= csr_wdata_i & INH_MASK;
  end

  assign cy_inhibit_o = r_minh[0];
  assign ir_inhibit_o = r_minh[2];

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    assign w_sel[k] = (w_num == 5'(k + HPM_FIRST));
    assign w_ext[k] = 64'(w_cnt[k]);

    hpm_counter #(
      .CNT_WIDTH  (CNT_WIDTH),
      .NUM_EVENTS (NUM_EVENTS)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .count_en_i (count_en_i),
      .event_i    (event_i),
      .inhibit_i  (r_minh[k + HPM_FIRST]),
      .evt_wr_i   (csr_wr_en_i & w_is_evt & w_sel[k]),
      .lo_wr_i    (csr_wr_en_i & w_is_lo  & w_sel[k]),
      .hi_wr_i    (csr_wr_en_i & w_is_hi  & w_sel[k]),
      .wdata_i    (csr_wdata_i),
      .cnt_o      (w_cnt[k]),
      .evt_o      (w_evt[k])
    );
  end

  // Combinational read mux; shadows alias the machine-mode halves.
  always_comb begin
    w_rdata = '0;
    if (w_is_inh) w_rdata = r_minh;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (w_sel[k]) begin
        if (w_is_evt) begin
          w_rdata[HPM_OF_BIT] = w_evt[k].of;
          w_rdata[7:0]        = w_evt[k].sel;
        end
        if (w_is_lo || w_is_slo) w_rdata = w_ext[k][31:0];
        if (w_is_hi || w_is_shi) w_rdata = w_ext[k][63:32];
      end
    end
    if (!csr_rd_en_i) w_rdata = '0;
  end

  assign csr_rdata_o = w_rdata;

  // Level interrupt: any OF flag on a counter that is still running.
  always_comb begin
    w_irq = 1'b0;
    for (int k = 0; k < NUM_CNT; k++) begin
      w_irq = w_irq | (w_evt[k].of & ~r_minh[k + HPM_FIRST]);
    end
  end

  assign ovf_irq_o = w_irq;

endmodule
